sm83_irq_ctrl: RTL and testbench
================================

# sm83_irq_ctrl

Parametrised interrupt controller for the SM83 core, the next-generation companion to the core's fetch/execute control. It holds the IF and IE registers as memory-mapped bytes and edge-detects up to eight peripheral request lines. It implements IME with the EI one-instruction delay and runs a request/acknowledge dispatch handshake that supplies the core with a vectored jump target. It also drives a HALT wake-up line.

## Interface
- N_IRQ, 5, number of interrupt sources, legal range 1..8; bit 0 is highest priority.
- VEC_BASE, 16'h0040, vector of source 0.
- VEC_STRIDE, 8, byte distance between consecutive vectors.
- IF_ADDR, 16'hFF0F, address of the IF register.
- IE_ADDR, 16'hFFFF, address of the IE register.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- irq_src  in  N_IRQ  level request lines from peripherals; the rising edge is significant.
- addr  in  16  bus address (core r_addr/w_addr).
- w_data  in  8  bus write data.
- w_wen  in  1  bus write enable.
- r_data  out  8  read data for IF/IE; 8'h00 when r_hit=0.
- r_hit  out  1  addr equals IF_ADDR or IE_ADDR.
- instr_boundary  in  1  single-cycle pulse; the core is about to fetch the next opcode.
- ei  in  1  pulse; an EI instruction completes (coincides with its instr_boundary).
- di  in  1  pulse; a DI instruction executes.
- reti  in  1  pulse; a RETI instruction executes.
- irq_req  out  1  dispatch request to the core.
- irq_vec  out  16  jump target, valid while irq_req=1.
- irq_ack  in  1  pulse; the core has pushed PC and is taking irq_vec.
- ime  out  1  current interrupt master enable.
- wake  out  1  at least one enabled interrupt is pending, independent of IME.

## Operation
- Edge detect: src_q <= irq_src every cycle. edge = irq_src & ~src_q.
- IF update each cycle: IF_next = ((wr_if ? w_data[N_IRQ-1:0] : IF) & ~clr) | edge.
  - clr is the one-hot of the dispatched source on a valid irq_ack.
  - A new edge always wins over a write or an ack clear.
- IE: 8-bit register, written in full on a write to IE_ADDR. Only IE[N_IRQ-1:0] takes part in arbitration.
- Reads:
  - IF reads as {1's in bits 7..N_IRQ, IF}.
  - IE reads all 8 bits.
- pending = IF & IE[N_IRQ-1:0]. wake = |pending.
- IME:
  - di clears IME immediately and cancels any EI in flight.
  - reti sets IME immediately.
  - ei sets ei_pend. At the next instr_boundary strictly after the ei cycle, IME <= 1 and ei_pend <= 0.
  - If di and ei occur in the same cycle, di wins.
- FSM, two states:
  - IDLE: irq_req=0. If IME=1, |pending=1 and instr_boundary=1, then latch idx = lowest set bit of pending, clear IME, clear ei_pend, and go to DISPATCH.
  - DISPATCH: irq_req=1; irq_vec = VEC_BASE + VEC_STRIDE*idx.
    - If pending[idx] drops (software cleared IF or IE), irq_vec becomes 16'h0000 (cancelled dispatch).
    - On irq_ack: clear IF[idx] only if pending[idx]=1, then return to IDLE.
    - di, ei and reti are ignored in DISPATCH.
- Vector arithmetic is 16-bit and wraps modulo 2^16.
- irq_vec = 16'h0000 in IDLE.

## Timing
- Reset values: IF=0, IE=0, IME=0, ei_pend=0, src_q=0, state IDLE.
  - Resulting outputs: irq_req=0, irq_vec=0, ime=0, wake=0.
  - r_data and r_hit are combinational from addr.
- A source held high through reset release sets IF on the first clock after release.
- irq_src rising before edge k: the IF bit is visible after edge k; wake follows with no extra delay.
- r_data and r_hit are combinational, same cycle as addr. Writes take effect at the clock edge.
- Dispatch: irq_req asserts the cycle after the qualifying instr_boundary and stays high until the cycle after irq_ack.
  - Minimum request-to-IDLE is 2 cycles.
  - irq_ack in IDLE is ignored.
- An IF clear by ack and an edge on the same bit in the same cycle leaves the bit set.
- rst mid-DISPATCH returns to IDLE immediately; the in-flight dispatch is lost.
- ime reflects the register value; it drops the cycle after dispatch entry.

## Test plan
- Priority: IE=8'h1F, IME=1, raise irq_src bits 2 and 4 together, then pulse instr_boundary.
  - Expect irq_vec=16'h0050 and irq_req=1.
  - After ack: IF=8'hF0, IME=0.
  - Second dispatch after reti and instr_boundary: 16'h0060.
- EI delay: IF bit0 set, IE=1, IME=0. Pulse ei at boundary 1.
  - No irq_req at boundary 1.
  - At boundary 2, ime=1; irq_req is not raised until the next boundary with IME=1.
  - di between boundaries 1 and 2 leaves IME=0.
- Cancel: in DISPATCH for idx 1, write IE=0.
  - Expect irq_vec=16'h0000.
  - ack leaves IF bit1 set; FSM returns to IDLE.
- Edge vs write: in the same cycle, write IF=8'h00 while irq_src bit3 rises.
  - Expect IF bit3=1; r_data at IF_ADDR = 8'hE8.
- HALT wake: IME=0, IE=8'h04, raise irq_src[2].
  - Expect wake=1 the cycle after the IF update and irq_req=0.
- Reset in DISPATCH: assert rst asynchronously.
  - Expect irq_req=0, irq_vec=0 and IF=IE=0 without waiting for a clock edge.

Source files
------------

// File: rtl/sm83_irq_ctrl.sv
// SM83 interrupt controller: IF/IE registers, rising-edge request capture, IME with
// EI delay, and a request/acknowledge dispatch handshake supplying the vector.
module sm83_irq_ctrl #(
  parameter int          N_IRQ      = 5,
  parameter logic [15:0] VEC_BASE   = 16'h0040,
  parameter int          VEC_STRIDE = 8,
  parameter logic [15:0] IF_ADDR    = 16'hFF0F,
  parameter logic [15:0] IE_ADDR    = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic [15:0]      addr,
  input  logic [7:0]       w_data,
  input  logic             w_wen,
  output logic [7:0]       r_data,
  output logic             r_hit,
  input  logic             instr_boundary,
  input  logic             ei,
  input  logic             di,
  input  logic             reti,
  output logic             irq_req,
  output logic [15:0]      irq_vec,
  input  logic             irq_ack,
  output logic             ime,
  output logic             wake
);

  typedef enum logic {S_IDLE, S_DISPATCH} state_t;

  state_t           r_state;
  logic [N_IRQ-1:0] r_if;
  logic [N_IRQ-1:0] r_src_q;
  logic [7:0]       r_ie;
  logic             r_ime;
  logic             r_ei_pend;
  logic [2:0]       r_idx;

  logic [N_IRQ-1:0] w_edge;
  logic [N_IRQ-1:0] w_pending;
  logic [7:0]       w_pend8;
  logic [7:0]       w_clr8;
  logic [N_IRQ-1:0] w_clr;
  logic [N_IRQ-1:0] w_if_next;
  logic [2:0]       w_first;
  logic             w_wr_if;
  logic             w_wr_ie;
  logic             w_take;
  logic [7:0]       w_if_rd;

  assign w_edge    = irq_src & ~r_src_q;
  assign w_pending = r_if & r_ie[N_IRQ-1:0];
  assign w_pend8   = 8'(w_pending);
  assign w_wr_if   = w_wen && (addr == IF_ADDR);
  assign w_wr_ie   = w_wen && (addr == IE_ADDR);

  // The ack only clears the bit it was dispatched for, and only if it is still pending.
  assign w_clr8    = (r_state == S_DISPATCH && irq_ack && w_pend8[r_idx]) ? (8'h01 << r_idx) : 8'h00;
  assign w_clr     = w_clr8[N_IRQ-1:0];
  assign w_if_next = ((w_wr_if ? w_data[N_IRQ-1:0] : r_if) & ~w_clr) | w_edge;

  assign w_take = (r_state == S_IDLE) && r_ime && (|w_pending) && instr_boundary;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_first = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_pending[i]) w_first = 3'(i);
    end
  end

  assign w_if_rd = (8'hFF << N_IRQ) | 8'(r_if);
  assign r_hit   = (addr == IF_ADDR) || (addr == IE_ADDR);
  assign r_data  = (addr == IF_ADDR) ? w_if_rd :
                   (addr == IE_ADDR) ? r_ie    : 8'h00;

  assign irq_req = (r_state == S_DISPATCH);
  assign irq_vec = (r_state == S_DISPATCH && w_pend8[r_idx])
                 ? VEC_BASE + 16'(VEC_STRIDE) * {13'd0, r_idx}
                 : 16'h0000;
  assign ime     = r_ime;
  assign wake    = |w_pending;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_if      <= '0;
      r_src_q   <= '0;
      r_ie      <= 8'h00;
      r_ime     <= 1'b0;
      r_ei_pend <= 1'b0;
      r_idx     <= 3'd0;
    end else begin
      r_src_q <= irq_src;
      r_if    <= w_if_next;
      if (w_wr_ie) r_ie <= w_data;

      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_idx     <= w_first;
            r_ime     <= 1'b0;
            r_ei_pend <= 1'b0;
            r_state   <= S_DISPATCH;
          end else if (di) begin
            r_ime     <= 1'b0;
            r_ei_pend <= 1'b0;
          end else begin
            // EI takes effect only at a boundary strictly after the EI cycle.
            if (reti || (instr_boundary && r_ei_pend)) r_ime <= 1'b1;
            if (ei)                                  r_ei_pend <= 1'b1;
            else if (instr_boundary && r_ei_pend)    r_ei_pend <= 1'b0;
          end
        end
        S_DISPATCH: begin
          if (irq_ack) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// Bench for sm83_irq_ctrl: directed scenarios against fixed expectations, then a
// randomized run compared cycle by cycle against a rule-level model.
module tb_sm83_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  irq_src;
  logic [15:0] addr;
  logic [7:0]  w_data;
  logic        w_wen;
  logic [7:0]  r_data;
  logic        r_hit;
  logic        instr_boundary, ei, di, reti, irq_ack;
  logic        irq_req;
  logic [15:0] irq_vec;
  logic        ime;
  logic        wake;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [4:0] m_if, m_prev;
  logic [7:0] m_ie;
  logic       m_ime, m_eip, m_disp;
  int         m_idx;

  sm83_irq_ctrl dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .addr(addr), .w_data(w_data),
    .w_wen(w_wen), .r_data(r_data), .r_hit(r_hit), .instr_boundary(instr_boundary),
    .ei(ei), .di(di), .reti(reti), .irq_req(irq_req), .irq_vec(irq_vec),
    .irq_ack(irq_ack), .ime(ime), .wake(wake)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_if = 0; m_prev = 0; m_ie = 0; m_ime = 0; m_eip = 0; m_disp = 0; m_idx = 0;
  endtask

  // Applies the controller rules for one rising edge using the inputs currently driven.
  task automatic model_update();
    logic [4:0] edg, pend, clr, nif, lowbit;
    edg  = irq_src & ~m_prev;
    pend = m_if & m_ie[4:0];
    clr  = 0;
    if (m_disp && irq_ack && pend[m_idx]) clr = 5'(1 << m_idx);
    nif = (((w_wen && addr == 16'hFF0F) ? w_data[4:0] : m_if) & ~clr) | edg;
    if (!m_disp) begin
      if (m_ime && pend != 0 && instr_boundary) begin
        lowbit = pend & (~pend + 5'd1);
        m_idx  = $clog2(lowbit);
        m_disp = 1; m_ime = 0; m_eip = 0;
      end else if (di) begin
        m_ime = 0; m_eip = 0;
      end else begin
        if (reti || (instr_boundary && m_eip)) m_ime = 1;
        if (ei) m_eip = 1;
        else if (instr_boundary && m_eip) m_eip = 0;
      end
    end else if (irq_ack) begin
      m_disp = 0;
    end
    m_if = nif;
    if (w_wen && addr == 16'hFFFF) m_ie = w_data;
    m_prev = irq_src;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    w_wen = 0; instr_boundary = 0; ei = 0; di = 0; reti = 0; irq_ack = 0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr = a; w_data = d; w_wen = 1;
    step();
  endtask

  task automatic test_reset();
    #3;
    total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", irq_req); end
    total++; if (irq_vec !== 16'h0000) begin bad++; $display("FAIL reset_vec: got %h want 0000", irq_vec); end
    total++; if (ime !== 1'b0 || wake !== 1'b0) begin bad++; $display("FAIL reset_ime_wake: got %b%b want 00", ime, wake); end
    addr = 16'hFF0F; #1;
    total++; if (r_data !== 8'hE0 || r_hit !== 1'b1) begin bad++; $display("FAIL reset_if_read: got %h/%b want e0/1", r_data, r_hit); end
    addr = 16'h1234; #1;
    total++; if (r_data !== 8'h00 || r_hit !== 1'b0) begin bad++; $display("FAIL miss_read: got %h/%b want 00/0", r_data, r_hit); end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_priority();
    wr(16'hFFFF, 8'h1F);
    reti = 1; step();
    total++; if (ime !== 1'b1) begin bad++; $display("FAIL prio_reti_ime: got %b want 1", ime); end
    irq_src = 5'b10100; step();
    total++; if (wake !== 1'b1 || irq_req !== 1'b0) begin bad++; $display("FAIL prio_wake: got %b/%b want 1/0", wake, irq_req); end
    instr_boundary = 1; step();
    total++; if (irq_req !== 1'b1 || irq_vec !== 16'h0050) begin bad++; $display("FAIL prio_vec2: got %b/%h want 1/0050", irq_req, irq_vec); end
    total++; if (ime !== 1'b0) begin bad++; $display("FAIL prio_ime_drop: got %b want 0", ime); end
    irq_ack = 1; step();
    addr = 16'hFF0F; #1;
    total++; if (r_data !== 8'hF0 || irq_req !== 1'b0 || ime !== 1'b0) begin bad++; $display("FAIL prio_after_ack: got %h/%b/%b want f0/0/0", r_data, irq_req, ime); end
    reti = 1; step();
    instr_boundary = 1; step();
    total++; if (irq_vec !== 16'h0060) begin bad++; $display("FAIL prio_vec4: got %h want 0060", irq_vec); end
    irq_ack = 1; step();
    irq_src = 0; step();
  endtask

  task automatic test_ei_delay();
    wr(16'hFFFF, 8'h01);
    wr(16'hFF0F, 8'h01);
    instr_boundary = 1; ei = 1; step();
    total++; if (irq_req !== 1'b0 || ime !== 1'b0) begin bad++; $display("FAIL ei_b1: got %b/%b want 0/0", irq_req, ime); end
    step();
    total++; if (ime !== 1'b0) begin bad++; $display("FAIL ei_mid: got %b want 0", ime); end
    instr_boundary = 1; step();
    total++; if (ime !== 1'b1 || irq_req !== 1'b0) begin bad++; $display("FAIL ei_b2: got %b/%b want 1/0", ime, irq_req); end
    instr_boundary = 1; step();
    total++; if (irq_req !== 1'b1 || irq_vec !== 16'h0040) begin bad++; $display("FAIL ei_b3: got %b/%h want 1/0040", irq_req, irq_vec); end
    irq_ack = 1; step();
    wr(16'hFF0F, 8'h01);
    instr_boundary = 1; ei = 1; step();
    di = 1; step();
    instr_boundary = 1; step();
    total++; if (ime !== 1'b0) begin bad++; $display("FAIL ei_di_cancel: got %b want 0", ime); end
    instr_boundary = 1; step();
    total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL ei_di_noreq: got %b want 0", irq_req); end
    wr(16'hFF0F, 8'h00);
  endtask

  task automatic test_cancel();
    wr(16'hFFFF, 8'h02);
    wr(16'hFF0F, 8'h02);
    reti = 1; step();
    instr_boundary = 1; step();
    total++; if (irq_vec !== 16'h0048) begin bad++; $display("FAIL cancel_vec1: got %h want 0048", irq_vec); end
    wr(16'hFFFF, 8'h00);
    total++; if (irq_req !== 1'b1 || irq_vec !== 16'h0000) begin bad++; $display("FAIL cancel_zero: got %b/%h want 1/0000", irq_req, irq_vec); end
    irq_ack = 1; step();
    addr = 16'hFF0F; #1;
    total++; if (irq_req !== 1'b0 || r_data !== 8'hE2) begin bad++; $display("FAIL cancel_ack: got %b/%h want 0/e2", irq_req, r_data); end
    wr(16'hFF0F, 8'h00);
  endtask

  task automatic test_edge_vs_write();
    addr = 16'hFF0F; w_data = 8'h00; w_wen = 1; irq_src = 5'b01000; step();
    total++; if (r_data !== 8'hE8) begin bad++; $display("FAIL edge_vs_write: got %h want e8", r_data); end
    irq_src = 0;
    wr(16'hFFFF, 8'h01);
    wr(16'hFF0F, 8'h01);
    reti = 1; step();
    instr_boundary = 1; step();
    total++; if (irq_vec !== 16'h0040) begin bad++; $display("FAIL edge_ack_vec: got %h want 0040", irq_vec); end
    irq_src = 5'b00001; irq_ack = 1; step();
    total++; if (r_data !== 8'hE1 || irq_req !== 1'b0) begin bad++; $display("FAIL edge_vs_ack: got %h/%b want e1/0", r_data, irq_req); end
    irq_src = 0;
    wr(16'hFF0F, 8'h00);
  endtask

  task automatic test_wake();
    wr(16'hFFFF, 8'h04);
    total++; if (wake !== 1'b0) begin bad++; $display("FAIL wake_idle: got %b want 0", wake); end
    irq_src = 5'b00100; step();
    total++; if (wake !== 1'b1 || irq_req !== 1'b0) begin bad++; $display("FAIL wake_set: got %b/%b want 1/0", wake, irq_req); end
    instr_boundary = 1; step();
    total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL wake_noreq: got %b want 0", irq_req); end
    irq_src = 0;
    wr(16'hFF0F, 8'h00);
    wr(16'hFFFF, 8'h00);
  endtask

  task automatic test_reset_in_dispatch();
    wr(16'hFFFF, 8'h01);
    wr(16'hFF0F, 8'h01);
    reti = 1; step();
    instr_boundary = 1; step();
    total++; if (irq_req !== 1'b1) begin bad++; $display("FAIL rstd_enter: got %b want 1", irq_req); end
    #2 rst = 1;
    #1;
    total++; if (irq_req !== 1'b0 || irq_vec !== 16'h0000 || ime !== 1'b0) begin bad++; $display("FAIL rstd_async: got %b/%h/%b want 0/0000/0", irq_req, irq_vec, ime); end
    addr = 16'hFF0F; #1;
    total++; if (r_data !== 8'hE0) begin bad++; $display("FAIL rstd_if: got %h want e0", r_data); end
    addr = 16'hFFFF; #1;
    total++; if (r_data !== 8'h00) begin bad++; $display("FAIL rstd_ie: got %h want 00", r_data); end
    irq_src = 5'b00010;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    step();
    addr = 16'hFF0F; #1;
    total++; if (r_data !== 8'hE2) begin bad++; $display("FAIL held_src_release: got %h want e2", r_data); end
    irq_src = 0;
    wr(16'hFF0F, 8'h00);
  endtask

  task automatic test_random();
    logic [7:0] exp_rd;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 1) == 0) irq_src = 5'($urandom);
      case ($urandom_range(0, 3))
        0: addr = 16'hFF0F;
        1: addr = 16'hFFFF;
        default: addr = 16'($urandom);
      endcase
      w_data         = 8'($urandom);
      w_wen          = ($urandom_range(0, 7) == 0);
      instr_boundary = ($urandom_range(0, 2) == 0);
      ei             = ($urandom_range(0, 11) == 0);
      di             = ($urandom_range(0, 15) == 0);
      reti           = ($urandom_range(0, 7) == 0);
      irq_ack        = ($urandom_range(0, 2) == 0);
      step();
      exp_rd = (addr == 16'hFF0F) ? (8'hE0 | 8'(m_if)) : (addr == 16'hFFFF) ? m_ie : 8'h00;
      total++; if (irq_req !== m_disp) begin bad++; $display("FAIL rnd_req @%0d: got %b want %b", n, irq_req, m_disp); end
      total++;
      if (irq_vec !== ((m_disp && ((m_if & m_ie[4:0]) >> m_idx) & 5'd1) ? 16'(16'h0040 + 8 * m_idx) : 16'h0000)) begin
        bad++; $display("FAIL rnd_vec @%0d: got %h want idx %0d disp %b", n, irq_vec, m_idx, m_disp);
      end
      total++; if (ime !== m_ime) begin bad++; $display("FAIL rnd_ime @%0d: got %b want %b", n, ime, m_ime); end
      total++; if (wake !== ((m_if & m_ie[4:0]) != 0)) begin bad++; $display("FAIL rnd_wake @%0d: got %b want %b", n, wake, (m_if & m_ie[4:0]) != 0); end
      total++; if (r_data !== exp_rd) begin bad++; $display("FAIL rnd_rdata @%0d: got %h want %h", n, r_data, exp_rd); end
      total++; if (r_hit !== (addr == 16'hFF0F || addr == 16'hFFFF)) begin bad++; $display("FAIL rnd_hit @%0d: got %b", n, r_hit); end
    end
  endtask

  initial begin
    rst = 1; irq_src = 0; addr = 0; w_data = 0; w_wen = 0;
    instr_boundary = 0; ei = 0; di = 0; reti = 0; irq_ack = 0;
    model_reset();
    test_reset();
    test_priority();
    test_ei_delay();
    test_cancel();
    test_edge_vs_write();
    test_wake();
    test_reset_in_dispatch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
